aes_round_ctrl: RTL

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_pkg.sv | 38 +++
 rtl/aes_round_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/aes_pkg.sv
// Shared encodings for the AES round controller: key-length codes, round
// counts and controller state type.
package aes_pkg;

  localparam logic [1:0] KL_128     = 2'b00;
  localparam logic [1:0] KL_192     = 2'b01;
  localparam logic [1:0] KL_256     = 2'b10;
  localparam logic [1:0] KL_ILLEGAL = 2'b11;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } state_t;

  // Illegal codes map to 0; callers gate on kl_legal() first.
  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    logic [3:0] nr;
    case (kl)
      KL_128:  nr = NR_128;
      KL_192:  nr = NR_192;
      KL_256:  nr = NR_256;
      default: nr = 4'd0;
    endcase
    return nr;
  endfunction

  function automatic logic kl_legal(input logic [1:0] kl);
    return (kl != KL_ILLEGAL);
  endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: accepts a block, walks LOAD / ROUND x(Nr-1) / FINAL,
// then holds the result in DONE until the consumer takes it.
module aes_round_ctrl
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  key_len,
  input  logic        decrypt,
  input  logic        abort,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        load,
  output logic        round_en,
  output logic        last_round,
  output logic        kx_en,
  output logic [3:0]  round_idx,
  output logic        mode_dec,
  output logic        busy,
  output logic        err,
  output logic [15:0] blk_cnt
);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_nr;
  logic [3:0]  r_cnt;
  logic        r_dec;
  logic        r_err;
  logic [15:0] r_blk_cnt;
  logic        w_accept;
  logic        w_legal;
  logic        w_in_flight;

  assign w_legal     = kl_legal(key_len);
  assign w_accept    = in_valid & in_ready;
  assign w_in_flight = (r_state == ST_LOAD) || (r_state == ST_ROUND) ||
                       (r_state == ST_FINAL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept && w_legal) w_next = ST_LOAD;
      ST_LOAD:  w_next = ST_ROUND;
      ST_ROUND: if (r_cnt == (r_nr - 4'd1)) w_next = ST_FINAL;
      ST_FINAL: w_next = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          w_next = (w_accept && w_legal) ? ST_LOAD : ST_IDLE;
        end
      end
      default:  w_next = ST_IDLE;
    endcase
    if (abort && w_in_flight) begin
      w_next = ST_IDLE;
    end
  end

  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    load       = 1'b0;
    round_en   = 1'b0;
    last_round = 1'b0;
    kx_en      = 1'b0;
    round_idx  = '0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_LOAD: begin
        load      = 1'b1;
        kx_en     = 1'b1;
        round_idx = r_dec ? r_nr : 4'd0;
      end
      ST_ROUND: begin
        round_en  = 1'b1;
        kx_en     = 1'b1;
        round_idx = r_dec ? (r_nr - r_cnt) : r_cnt;
      end
      ST_FINAL: begin
        round_en   = 1'b1;
        last_round = 1'b1;
        round_idx  = r_dec ? 4'd0 : r_nr;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Round counter runs 1..Nr-1 through ROUND; the index direction is applied
  // at the output so one counter serves both encrypt and decrypt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_state == ST_LOAD) begin
      r_cnt <= 4'd1;
    end else if (r_state == ST_ROUND) begin
      r_cnt <= r_cnt + 4'd1;
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_nr  <= '0;
      r_dec <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept & ~w_legal;
      if (w_accept && w_legal) begin
        r_nr  <= nr_of(key_len);
        r_dec <= decrypt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_blk_cnt <= '0;
    end else if (out_valid && out_ready) begin
      r_blk_cnt <= r_blk_cnt + 16'd1;
    end
  end

  assign mode_dec = r_dec;
  assign busy     = (r_state != ST_IDLE);
  assign err      = r_err;
  assign blk_cnt  = r_blk_cnt;

endmodule
